// File: rtl/qspi_psram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qspi_psram_pkg
//  Description : Shared constants and types for the QSPI/QPI PSRAM target:
//                command opcodes, link address width and the FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package qspi_psram_pkg;

    // The link always carries a 24-bit byte address.
    localparam int LINK_ADDR_W = 24;

    localparam logic [7:0] CMD_RST_EN = 8'h66;
    localparam logic [7:0] CMD_RST    = 8'h99;
    localparam logic [7:0] CMD_QPI_EN = 8'h35;
    localparam logic [7:0] CMD_READ   = 8'h0B;
    localparam logic [7:0] CMD_WRITE  = 8'h38;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RDATA  = 3'd4,
        ST_WDATA  = 3'd5,
        ST_IGNORE = 3'd6
    } state_e;

endpackage
`default_nettype wire

// File: rtl/qspi_psram_target_sync.sv
`default_nettype none
// ============================================================================
//  Module      : qspi_link_sync
//  Description : Brings the QSPI link into the system clock domain. Two-flop
//                synchronizers on spi_clk, spi_cs_n and spi_io_i, followed by
//                edge detection producing one-clk pulses.
//  Ports       : clk, rst_n          - system clock, async active-low reset
//                spi_clk, spi_cs_n   - raw link clock / chip select
//                spi_io_i[3:0]       - raw link data
//                io_s[3:0]           - synchronized data, aligned with rise
//                rise / fall         - spi_clk edge pulses, only while CS low
//                cs_active           - synchronized CS is asserted
//                cs_start / cs_end   - synchronized CS fall / rise pulses
//  Revision    : 1.0 - initial release
// ============================================================================
module qspi_link_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_clk,
    input  logic       spi_cs_n,
    input  logic [3:0] spi_io_i,
    output logic [3:0] io_s,
    output logic       rise,
    output logic       fall,
    output logic       cs_active,
    output logic       cs_start,
    output logic       cs_end
);

    // Bit [0] metastability stage, [1] synchronized value, [2] previous value.
    logic [2:0] sclk_q, sclk_d;
    logic [2:0] cs_q,   cs_d;
    logic [3:0] io_meta_q, io_meta_d;
    logic [3:0] io_sync_q, io_sync_d;

    always_comb begin
        sclk_d    = {sclk_q[1:0], spi_clk};
        cs_d      = {cs_q[1:0], spi_cs_n};
        io_meta_d = spi_io_i;
        io_sync_d = io_meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q    <= 3'b000;
            cs_q      <= 3'b111;
            io_meta_q <= 4'h0;
            io_sync_q <= 4'h0;
        end else begin
            sclk_q    <= sclk_d;
            cs_q      <= cs_d;
            io_meta_q <= io_meta_d;
            io_sync_q <= io_sync_d;
        end
    end

    // Data shares the clock's synchronizer depth, so io_s is the value that
    // was stable on the link at the rising spi_clk edge.
    assign io_s      = io_sync_q;
    assign cs_active = ~cs_q[1];
    assign rise      = cs_active &  sclk_q[1] & ~sclk_q[2];
    assign fall      = cs_active & ~sclk_q[1] &  sclk_q[2];
    assign cs_start  = ~cs_q[1] &  cs_q[2];
    assign cs_end    =  cs_q[1] & ~cs_q[2];

endmodule
`default_nettype wire

// File: rtl/qspi_psram_target.sv
`default_nettype none
// ============================================================================
//  Module      : qspi_psram_target
//  Description : QSPI/QPI PSRAM responder. Oversamples the link with clk,
//                decodes SPI init commands (0x66, 0x99, 0x35) and QPI read
//                (0x0B) / write (0x38), and serves data from a byte-wide
//                synchronous memory port (1-clk read latency).
//  Ports       : clk, rst_n                  - system clock, async reset
//                spi_clk, spi_cs_n, spi_io_i - link inputs
//                spi_io_o, spi_io_oe         - link data out and enable
//                mem_addr, mem_rd, mem_wr,
//                mem_wdata, mem_rdata        - local memory port
//                qpi_mode                    - quad mode active
//                cmd_err                     - pulse on unsupported command
//  Revision    : 1.0 - initial release
// ============================================================================
module qspi_psram_target
    import qspi_psram_pkg::*;
#(
    parameter int ADDR_W      = 24,
    parameter int WAIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_clk,
    input  logic              spi_cs_n,
    input  logic [3:0]        spi_io_i,
    output logic [3:0]        spi_io_o,
    output logic              spi_io_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              qpi_mode,
    output logic              cmd_err
);

    logic [3:0] io_s;
    logic       rise, fall, cs_active, cs_start, cs_end;

    qspi_link_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_clk   (spi_clk),
        .spi_cs_n  (spi_cs_n),
        .spi_io_i  (spi_io_i),
        .io_s      (io_s),
        .rise      (rise),
        .fall      (fall),
        .cs_active (cs_active),
        .cs_start  (cs_start),
        .cs_end    (cs_end)
    );

    state_e                 state_q,     state_d;
    logic [3:0]             bit_cnt_q,   bit_cnt_d;
    logic [6:0]             cmd_q,       cmd_d;
    logic                   is_read_q,   is_read_d;
    logic [LINK_ADDR_W-1:0] addr_q,      addr_d;
    logic                   qpi_q,       qpi_d;
    logic                   rst_en_q,    rst_en_d;
    logic                   cmd_err_q,   cmd_err_d;
    logic                   mem_rd_q,    mem_rd_d;
    logic                   rd_pend_q,   rd_pend_d;
    logic                   mem_wr_q,    mem_wr_d;
    logic [7:0]             mem_wdata_q, mem_wdata_d;
    logic [ADDR_W-1:0]      mem_addr_q,  mem_addr_d;
    logic [3:0]             io_o_q,      io_o_d;
    logic                   oe_q,        oe_d;
    logic [7:0]             wait_cnt_q,  wait_cnt_d;
    logic [7:0]             byte_q,      byte_d;
    logic [3:0]             hi_nib_q,    hi_nib_d;
    // Read: 0 = low nibble goes out next. Write: 1 = high nibble held.
    logic                   phase_q,     phase_d;

    logic [7:0]             cmd_next;
    logic [3:0]             bit_sum;
    logic [LINK_ADDR_W-1:0] addr_next;
    logic [LINK_ADDR_W-1:0] addr_inc;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        cmd_d       = cmd_q;
        is_read_d   = is_read_q;
        addr_d      = addr_q;
        qpi_d       = qpi_q;
        rst_en_d    = rst_en_q;
        wait_cnt_d  = wait_cnt_q;
        byte_d      = byte_q;
        hi_nib_d    = hi_nib_q;
        phase_d     = phase_q;
        io_o_d      = io_o_q;
        oe_d        = oe_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cmd_err_d   = 1'b0;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        rd_pend_d   = mem_rd_q;

        cmd_next  = qpi_q ? {cmd_q[3:0], io_s} : {cmd_q, io_s[0]};
        bit_sum   = bit_cnt_q + (qpi_q ? 4'd4 : 4'd1);
        addr_next = {addr_q[LINK_ADDR_W-5:0], io_s};
        addr_inc  = addr_q + LINK_ADDR_W'(1);

        if (cs_end) begin
            // Deselect wins over everything: drop partial bytes and any
            // prefetch still in flight.
            state_d   = ST_IDLE;
            oe_d      = 1'b0;
            rd_pend_d = 1'b0;
            phase_d   = 1'b0;
        end else begin
            if (rd_pend_q) begin
                byte_d = mem_rdata;
            end
            case (state_q)
                ST_IDLE: begin
                    if (cs_start) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = 4'd0;
                    end
                end
                ST_CMD: begin
                    if (rise) begin
                        cmd_d     = cmd_next[6:0];
                        bit_cnt_d = bit_sum;
                        if (bit_sum == 4'd8) begin
                            bit_cnt_d = 4'd0;
                            rst_en_d  = 1'b0;
                            state_d   = ST_IGNORE;
                            case (cmd_next)
                                CMD_RST_EN: rst_en_d = 1'b1;
                                CMD_RST: begin
                                    if (rst_en_q) begin
                                        qpi_d = 1'b0;
                                    end else begin
                                        cmd_err_d = 1'b1;
                                    end
                                end
                                CMD_QPI_EN: qpi_d = 1'b1;
                                CMD_READ, CMD_WRITE: begin
                                    if (qpi_q) begin
                                        state_d   = ST_ADDR;
                                        is_read_d = (cmd_next == CMD_READ);
                                    end else begin
                                        cmd_err_d = 1'b1;
                                    end
                                end
                                default: cmd_err_d = 1'b1;
                            endcase
                        end
                    end
                end
                ST_ADDR: begin
                    if (rise) begin
                        addr_d    = addr_next;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd5) begin
                            bit_cnt_d = 4'd0;
                            phase_d   = 1'b0;
                            if (is_read_q) begin
                                state_d    = ST_WAIT;
                                wait_cnt_d = 8'd0;
                                mem_rd_d   = 1'b1;
                                mem_addr_d = addr_next[ADDR_W-1:0];
                            end else begin
                                state_d = ST_WDATA;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (rise && (wait_cnt_q != 8'(WAIT_CYCLES))) begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                    if (fall && (wait_cnt_q == 8'(WAIT_CYCLES))) begin
                        oe_d    = 1'b1;
                        io_o_d  = byte_q[7:4];
                        phase_d = 1'b0;
                        state_d = ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (fall) begin
                        if (!phase_q) begin
                            // The byte is fully on the wire once the low
                            // nibble is registered, so the next prefetch
                            // may overwrite byte_q.
                            io_o_d     = byte_q[3:0];
                            addr_d     = addr_inc;
                            mem_rd_d   = 1'b1;
                            mem_addr_d = addr_inc[ADDR_W-1:0];
                            phase_d    = 1'b1;
                        end else begin
                            io_o_d  = byte_q[7:4];
                            phase_d = 1'b0;
                        end
                    end
                end
                ST_WDATA: begin
                    if (rise) begin
                        if (!phase_q) begin
                            hi_nib_d = io_s;
                            phase_d  = 1'b1;
                        end else begin
                            mem_wr_d    = 1'b1;
                            mem_wdata_d = {hi_nib_q, io_s};
                            mem_addr_d  = addr_q[ADDR_W-1:0];
                            addr_d      = addr_inc;
                            phase_d     = 1'b0;
                        end
                    end
                end
                ST_IGNORE: begin
                    if (!cs_active) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 4'd0;
            cmd_q       <= 7'd0;
            is_read_q   <= 1'b0;
            addr_q      <= '0;
            qpi_q       <= 1'b0;
            rst_en_q    <= 1'b0;
            cmd_err_q   <= 1'b0;
            mem_rd_q    <= 1'b0;
            rd_pend_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= 8'd0;
            mem_addr_q  <= '0;
            io_o_q      <= 4'd0;
            oe_q        <= 1'b0;
            wait_cnt_q  <= 8'd0;
            byte_q      <= 8'd0;
            hi_nib_q    <= 4'd0;
            phase_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            cmd_q       <= cmd_d;
            is_read_q   <= is_read_d;
            addr_q      <= addr_d;
            qpi_q       <= qpi_d;
            rst_en_q    <= rst_en_d;
            cmd_err_q   <= cmd_err_d;
            mem_rd_q    <= mem_rd_d;
            rd_pend_q   <= rd_pend_d;
            mem_wr_q    <= mem_wr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_addr_q  <= mem_addr_d;
            io_o_q      <= io_o_d;
            oe_q        <= oe_d;
            wait_cnt_q  <= wait_cnt_d;
            byte_q      <= byte_d;
            hi_nib_q    <= hi_nib_d;
            phase_q     <= phase_d;
        end
    end

    assign spi_io_o  = io_o_q;
    assign spi_io_oe = oe_q;
    assign mem_addr  = mem_addr_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = mem_wdata_q;
    assign qpi_mode  = qpi_q;
    assign cmd_err   = cmd_err_q;

endmodule
`default_nettype wire

// File: tb/tb_qspi_psram_target.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_qspi_psram_target
//  Description : Self-checking bench for qspi_psram_target. A 24-bit and an
//                8-bit address instance share one link; write scoreboards
//                hold expected {addr,data} per instance, read nibbles are
//                queued and compared as the initiator samples them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_qspi_psram_target;
    import qspi_psram_pkg::*;

    localparam int H     = 80;   // half spi_clk period (clk period 10 ns)
    localparam int WAITC = 4;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       spi_clk  = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic [3:0] spi_io_i = 4'h0;

    logic [3:0]  io_o24, io_o8;
    logic        oe24, oe8, rd24, rd8, wr24, wr8, qpi24, qpi8, err24, err8;
    logic [23:0] addr24;
    logic [7:0]  addr8;
    logic [7:0]  wdata24, wdata8;
    logic [7:0]  rdata24 = 8'h00;
    logic [7:0]  rdata8  = 8'h00;
    logic [7:0]  mem24 [4096];
    logic [7:0]  mem8  [256];

    int tests = 0;
    int fails = 0;
    int rd_cnt24 = 0, wr_cnt24 = 0, err_cnt = 0, oe_cnt = 0, both_cnt = 0;

    logic [31:0] exp_wr24 [$];
    logic [15:0] exp_wr8  [$];
    logic [3:0]  exp_nib  [$];

    always #5 clk = ~clk;

    qspi_psram_target #(.ADDR_W(24), .WAIT_CYCLES(WAITC)) dut24 (
        .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n),
        .spi_io_i(spi_io_i), .spi_io_o(io_o24), .spi_io_oe(oe24),
        .mem_addr(addr24), .mem_rd(rd24), .mem_wr(wr24), .mem_wdata(wdata24),
        .mem_rdata(rdata24), .qpi_mode(qpi24), .cmd_err(err24)
    );

    qspi_psram_target #(.ADDR_W(8), .WAIT_CYCLES(WAITC)) dut8 (
        .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n),
        .spi_io_i(spi_io_i), .spi_io_o(io_o8), .spi_io_oe(oe8),
        .mem_addr(addr8), .mem_rd(rd8), .mem_wr(wr8), .mem_wdata(wdata8),
        .mem_rdata(rdata8), .qpi_mode(qpi8), .cmd_err(err8)
    );

    // Synchronous byte memories, one clk read latency.
    always @(posedge clk) begin
        if (wr24) mem24[addr24[11:0]] <= wdata24;
        if (rd24) rdata24 <= mem24[addr24[11:0]];
        if (wr8)  mem8[addr8] <= wdata8;
        if (rd8)  rdata8 <= mem8[addr8];
    end

    // ---------------- link driver helpers ----------------
    task automatic spi_cycle(input logic [3:0] v);
        spi_io_i = v;
        #H; spi_clk = 1'b1;
        #H; spi_clk = 1'b0;
    endtask

    task automatic cs_begin();
        spi_cs_n = 1'b0;
        #H;
    endtask

    task automatic cs_finish();
        #H; spi_cs_n = 1'b1;
        #(4*H);
    endtask

    task automatic send_spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) spi_cycle({3'b000, b[i]});
    endtask

    task automatic send_qpi_byte(input logic [7:0] b);
        spi_cycle(b[7:4]);
        spi_cycle(b[3:0]);
    endtask

    task automatic qpi_header(input logic [7:0] cmd, input logic [23:0] a);
        send_qpi_byte(cmd);
        for (int i = 0; i < 3; i++) send_qpi_byte(a[23-8*i -: 8]);
    endtask

    // ---------------- write scoreboard consumer ----------------
    task automatic monitor_loop();
        logic [31:0] e24;
        logic [15:0] e8;
        forever begin
            @(negedge clk);
            if (rd24)  rd_cnt24++;
            if (err24) err_cnt++;
            if (oe24)  oe_cnt++;
            if ((rd24 && wr24) || (rd8 && wr8)) both_cnt++;
            if (wr24) begin
                wr_cnt24++;
                tests++;
                if (exp_wr24.size() == 0) begin
                    fails++;
                    $display("FAIL wr24_extra: got addr=%h data=%h, required no write", addr24, wdata24);
                end else begin
                    e24 = exp_wr24.pop_front();
                    if ({addr24, wdata24} !== e24) begin
                        fails++;
                        $display("FAIL wr24: got addr=%h data=%h, required addr=%h data=%h",
                                 addr24, wdata24, e24[31:8], e24[7:0]);
                    end
                end
            end
            if (wr8) begin
                tests++;
                if (exp_wr8.size() == 0) begin
                    fails++;
                    $display("FAIL wr8_extra: got addr=%h data=%h, required no write", addr8, wdata8);
                end else begin
                    e8 = exp_wr8.pop_front();
                    if ({addr8, wdata8} !== e8) begin
                        fails++;
                        $display("FAIL wr8: got addr=%h data=%h, required addr=%h data=%h",
                                 addr8, wdata8, e8[15:8], e8[7:0]);
                    end
                end
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        tests++; if (oe24 !== 1'b0)   begin fails++; $display("FAIL reset_oe: got %b, required 0", oe24); end
        tests++; if (io_o24 !== 4'h0) begin fails++; $display("FAIL reset_io: got %h, required 0", io_o24); end
        tests++; if (qpi24 !== 1'b0)  begin fails++; $display("FAIL reset_qpi: got %b, required 0", qpi24); end
        tests++; if ({rd24, wr24, err24} !== 3'b000) begin
            fails++; $display("FAIL reset_strobes: got rd/wr/err=%b, required 000", {rd24, wr24, err24});
        end
        tests++; if ({addr24, wdata24} !== 32'h0) begin
            fails++; $display("FAIL reset_mem: got addr=%h wdata=%h, required 0", addr24, wdata24);
        end
    endtask

    task automatic test_err_read_spi();
        int e0 = err_cnt;
        int r0 = rd_cnt24;
        cs_begin(); send_spi_byte(CMD_READ); cs_finish();
        tests++; if (err_cnt - e0 != 1) begin fails++; $display("FAIL err_pulse: got %0d cycles, required 1", err_cnt - e0); end
        tests++; if (rd_cnt24 != r0)    begin fails++; $display("FAIL err_no_rd: got %0d reads, required 0", rd_cnt24 - r0); end
        tests++; if (qpi24 !== 1'b0)    begin fails++; $display("FAIL err_qpi: got %b, required 0", qpi24); end
    endtask

    task automatic test_spi_init();
        int e0 = err_cnt;
        int o0 = oe_cnt;
        cs_begin(); send_spi_byte(CMD_RST_EN); cs_finish();
        cs_begin(); send_spi_byte(CMD_RST);    cs_finish();
        tests++; if (qpi24 !== 1'b0) begin fails++; $display("FAIL init_qpi_before: got %b, required 0", qpi24); end
        cs_begin(); send_spi_byte(CMD_QPI_EN); cs_finish();
        tests++; if ({qpi24, qpi8} !== 2'b11) begin fails++; $display("FAIL init_qpi_after: got %b, required 11", {qpi24, qpi8}); end
        tests++; if (err_cnt != e0) begin fails++; $display("FAIL init_err: got %0d pulses, required 0", err_cnt - e0); end
        tests++; if (oe_cnt != o0)  begin fails++; $display("FAIL init_oe: got %0d oe cycles, required 0", oe_cnt - o0); end
    endtask

    task automatic test_rst_without_en();
        cs_begin(); send_qpi_byte(CMD_RST); cs_finish();
        tests++; if (qpi24 !== 1'b1) begin fails++; $display("FAIL rst_no_en_qpi: got %b, required 1", qpi24); end
    endtask

    task automatic test_write();
        int w0 = wr_cnt24;
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            b = {4'(2*i), 4'(2*i+1)};
            exp_wr24.push_back({24'h000120 + 24'(i), b});
            exp_wr8.push_back({8'h20 + 8'(i), b});
        end
        cs_begin();
        qpi_header(CMD_WRITE, 24'h000120);
        for (int i = 0; i < 8; i++) send_qpi_byte({4'(2*i), 4'(2*i+1)});
        cs_finish();
        tests++; if (wr_cnt24 - w0 != 8) begin fails++; $display("FAIL write_count: got %0d, required 8", wr_cnt24 - w0); end
        tests++; if (exp_wr24.size() + exp_wr8.size() != 0) begin
            fails++; $display("FAIL write_pending: got %0d outstanding, required 0", exp_wr24.size() + exp_wr8.size());
        end
    endtask

    task automatic test_read();
        logic [3:0] e;
        cs_begin();
        qpi_header(CMD_READ, 24'h000120);
        for (int d = 0; d < WAITC; d++) begin
            spi_io_i = 4'h0;
            #H; spi_clk = 1'b1;
            #H;
            if (d == WAITC-1) begin
                tests++; if (oe24 !== 1'b0) begin fails++; $display("FAIL read_oe_early: got %b, required 0", oe24); end
            end
            spi_clk = 1'b0;
        end
        for (int n = 0; n < 16; n++) exp_nib.push_back(4'(n));
        for (int n = 0; n < 16; n++) begin
            #H;
            e = exp_nib.pop_front();
            tests++;
            if ({oe24, io_o24} !== {1'b1, e}) begin
                fails++; $display("FAIL read_nib%0d: got oe=%b io=%h, required oe=1 io=%h", n, oe24, io_o24, e);
            end
            spi_clk = 1'b1;
            #H; spi_clk = 1'b0;
        end
        cs_finish();
        tests++; if (oe24 !== 1'b0) begin fails++; $display("FAIL read_oe_release: got %b, required 0", oe24); end
    endtask

    task automatic test_wrap();
        exp_wr24.push_back({24'h0000FF, 8'h5A});
        exp_wr24.push_back({24'h000100, 8'hA5});
        exp_wr8.push_back({8'hFF, 8'h5A});
        exp_wr8.push_back({8'h00, 8'hA5});
        cs_begin();
        qpi_header(CMD_WRITE, 24'h0000FF);
        send_qpi_byte(8'h5A);
        send_qpi_byte(8'hA5);
        cs_finish();
        tests++; if (exp_wr24.size() + exp_wr8.size() != 0) begin
            fails++; $display("FAIL wrap_pending: got %0d outstanding, required 0", exp_wr24.size() + exp_wr8.size());
        end
    endtask

    task automatic test_abort();
        int w0 = wr_cnt24;
        exp_wr24.push_back({24'h000200, 8'h3C});
        exp_wr8.push_back({8'h00, 8'h3C});
        cs_begin();
        qpi_header(CMD_WRITE, 24'h000200);
        spi_cycle(4'h3);
        spi_cycle(4'hC);
        spi_cycle(4'h7);
        @(negedge clk);
        spi_cs_n = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        tests++; if (dut24.state_q !== ST_WDATA) begin
            fails++; $display("FAIL abort_state_early: got %0d, required %0d", dut24.state_q, ST_WDATA);
        end
        @(posedge clk); #1;
        tests++; if (dut24.state_q !== ST_IDLE) begin
            fails++; $display("FAIL abort_state_idle: got %0d, required %0d", dut24.state_q, ST_IDLE);
        end
        tests++; if (oe24 !== 1'b0) begin fails++; $display("FAIL abort_oe: got %b, required 0", oe24); end
        #(4*H);
        tests++; if (wr_cnt24 - w0 != 1) begin fails++; $display("FAIL abort_count: got %0d, required 1", wr_cnt24 - w0); end
    endtask

    task automatic test_reset_mid_read();
        cs_begin();
        qpi_header(CMD_READ, 24'h000120);
        for (int d = 0; d < WAITC; d++) spi_cycle(4'h0);
        for (int n = 0; n < 4; n++) spi_cycle(4'h0);
        #H;
        tests++; if (oe24 !== 1'b1) begin fails++; $display("FAIL midrd_oe_active: got %b, required 1", oe24); end
        rst_n = 1'b0;
        #1;
        tests++; if ({oe24, qpi24} !== 2'b00) begin
            fails++; $display("FAIL midrd_reset: got oe/qpi=%b, required 00", {oe24, qpi24});
        end
        #20 rst_n = 1'b1;
        spi_cs_n = 1'b1;
        #(4*H);
    endtask

    task automatic test_final();
        tests++; if (both_cnt != 0) begin fails++; $display("FAIL rd_wr_overlap: got %0d cycles, required 0", both_cnt); end
        tests++; if (exp_wr24.size() + exp_wr8.size() != 0) begin
            fails++; $display("FAIL final_pending: got %0d outstanding, required 0", exp_wr24.size() + exp_wr8.size());
        end
    endtask

    initial begin
        fork
            monitor_loop();
        join_none
        test_reset();
        test_err_read_spi();
        test_spi_init();
        test_rst_without_en();
        test_write();
        test_read();
        test_wrap();
        test_abort();
        test_reset_mid_read();
        test_final();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/qspi_psram_target.md
Name: qspi_psram_target

Overview:
- Synthesizable QSPI/QPI PSRAM target (responder) for the other end of the PSRAM link.
- Uses: loopback self-test of the memory controller on a second FPGA pin bank, and on-chip PSRAM emulation when no PSRAM is fitted.
- Oversamples the link with the system clock and decodes SPI-mode init commands (0x66, 0x99, 0x35) and QPI read (0x0B) / write (0x38).
- Serves reads and writes from a local byte-wide synchronous memory port.

Parameters:
- ADDR_W, 24, byte address width of the local memory port. The link address is 24 bits; only the low ADDR_W bits are used.
- WAIT_CYCLES, 4, dummy spi_clk cycles between the last 0x0B address nibble and the first data nibble.

Ports:
- clk  in  1  system clock; frequency ≥ 8× spi_clk.
- rst_n  in  1  asynchronous active-low reset.
- spi_clk  in  1  link clock from the initiator; idles low while CS is high.
- spi_cs_n  in  1  link chip select, active low.
- spi_io_i  in  4  link data in; io[0] carries SI in SPI mode.
- spi_io_o  out  4  link data out.
- spi_io_oe  out  1  output enable for spi_io_o.
- mem_addr  out  ADDR_W  local memory byte address.
- mem_rd  out  1  read strobe; data arrives on mem_rdata exactly 1 clk later.
- mem_wr  out  1  one-cycle write strobe.
- mem_wdata  out  8  write byte.
- mem_rdata  in  8  read byte.
- qpi_mode  out  1  1 = quad (QPI) mode active.
- cmd_err  out  1  one-cycle pulse on an unsupported command byte.

Behaviour:
- Reset values: spi_io_o=0, spi_io_oe=0, mem_rd=0, mem_wr=0, mem_wdata=0, mem_addr=0, qpi_mode=0, cmd_err=0, state=IDLE, rst_en=0.
- Input sync: spi_clk, spi_cs_n and spi_io_i pass through 2-flop synchronizers.
- Edge detect: rise = sync 0→1, fall = 1→0, both gated by synchronized CS low.
- Sampling: data is sampled on the rise pulse; the target drives new output on the fall pulse.
- Bit order: bits MSB first; nibbles high nibble first.
  - SPI mode: 1 bit per rise, taken from io[0].
  - QPI mode: 4 bits per rise.
- State machine:
  - IDLE: CS fall (synced) → CMD; clear the bit counter.
  - CMD: after 8 bits, decode the command.
    - 0x66 → rst_en=1, then IGNORE.
    - 0x99 with rst_en=1 → qpi_mode=0, rst_en=0, then IGNORE.
    - 0x35 → qpi_mode=1, then IGNORE.
    - 0x0B or 0x38 while qpi_mode=1 → ADDR.
    - Anything else → cmd_err pulse, then IGNORE.
    - Any command other than 0x66 clears rst_en.
  - ADDR: collect 6 nibbles (24 bits) into addr.
    - 0x0B → WAIT, and assert mem_rd with mem_addr=addr[ADDR_W-1:0] one cycle after the last nibble is captured.
    - 0x38 → WDATA.
  - WAIT: count WAIT_CYCLES rise pulses. The prefetched byte is latched into the shift register 1 clk after mem_rd.
    - On the fall after the last dummy rise: spi_io_oe=1, spi_io_o = high nibble.
    - Then → RDATA.
  - RDATA: each fall presents the next nibble.
    - After the low nibble is presented: addr+1, mem_rd for the next byte (prefetch completes well before the next fall because clk ≥ 8× spi_clk).
    - Burst length is unbounded.
  - WDATA: every 2nd rise → mem_wr for 1 clk with mem_wdata = {hi,lo}, mem_addr=addr; then addr+1.
  - IGNORE: stay until CS rises; io lines are not driven.
- Address: wraps modulo 2^ADDR_W; no page boundary.
- CS rise (synced) in any state:
  - Go to IDLE on the next clk; spi_io_oe=0 the same cycle.
  - A partial write byte is discarded with no mem_wr; a pending prefetch is discarded.
- Simultaneous rise and CS rise: not possible after the synchronizers because CS is sampled first. CS deassert takes priority.
- Async reset mid-transaction: all state returns to reset values and qpi_mode=0. The initiator must redo the init sequence.
- mem_rd and mem_wr are never asserted in the same cycle.

Decomposition:
- Shared package qspi_psram_pkg:
  - command constants CMD_RST_EN=0x66, CMD_RST=0x99, CMD_QPI_EN=0x35, CMD_READ=0x0B, CMD_WRITE=0x38;
  - state enum;
  - address width constant 24.
- Sub-module qspi_link_sync: 2-flop synchronizers plus rise/fall/cs_active pulse generation. Reused by the initiator loopback bench.

Test Plan:
- SPI init: send 0x66, CS high, 0x99, CS high, 0x35 → qpi_mode 0→1 after the 0x35 byte; cmd_err stays 0; spi_io_oe stays 0.
- QPI write: 0x38, address 0x000120, data 0x0123456789ABCDEF → 8 mem_wr pulses, addresses 0x120..0x127, bytes 0x01,0x23,…,0xEF.
- QPI read: 0x0B, address 0x000120, 4 dummy cycles, 16 nibbles (memory preloaded as above) → nibbles 0,1,2,…,F on spi_io_o; oe rises on the fall after the 4th dummy rise.
- Wrap: ADDR_W=8, write 2 bytes at address 0xFF → mem_addr 0xFF then 0x00.
- Abort: CS high after 3 nibbles of write data → exactly one mem_wr; the state machine is in IDLE 1 clk after the synced CS rise; oe=0.
- Errors:
  - 0x0B sent while qpi_mode=0 → cmd_err pulse, no mem_rd.
  - 0x99 without a preceding 0x66 → qpi_mode unchanged.
  - rst_n low mid-read → oe=0 and qpi_mode=0 immediately.
